alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
Shares one ALU_8bit instance between two requesters (req0, req1) using round-robin arbitration.
Each requester presents an opcode, operands and carry/borrow-in over a valid/ready handshake. The block registers the granted operation, runs it through the internal ALU, and returns the registered result with a requester tag over a valid/ready output handshake.
It also keeps a completed-operation counter per requester.

Parameters:
DATA_WIDTH, 8, operand width N; passed to ALU_8bit.
CNT_W, 8, width of each per-requester completion counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation pending.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_sel  in  2  opcode: 0 ADD, 1 SUB, 2 CMP, 3 SQR.
req0_a, req0_b  in  N  operands.
req0_cin, req0_bin  in  1  carry-in, borrow-in.
req1_*  same set of ports as req0_*, for requester 1.
out_valid  out  1  result available.
out_ready  in  1  consumer takes the result.
out_id  out  1  requester that issued the result.
out_y  out  2N  ALU Y.
out_cout, out_bout, out_gr, out_le, out_eq  out  1 each  ALU flags.
busy  out  1  high whenever state is not IDLE.
cnt0, cnt1  out  CNT_W  completed operations per requester.

Behaviour:
- Reset (async, active-high), at any time including mid-operation:
  - State goes to IDLE; the in-flight operation is discarded.
  - out_valid, out_id, out_y, all flags, busy, cnt0, cnt1 are 0.
  - Operand registers are 0.
  - last_grant = 1, so req0 wins the first contention.
- ALU contract:
  - ADD: Y = A+B+Cin zero-extended; Cout = bit N of the sum.
  - SUB: Y = (A-B-Bin) mod 2^N, zero-extended; Bout = 1 iff A < B+Bin.
  - CMP: gr = A>B, le = A<B, eq = A==B; Y = 0.
  - SQR: Y = A*A.
  - Flags not defined for an opcode are 0.
- FSM, three states:
  - IDLE:
    - reqX_ready is combinational; it is high only in IDLE, for the granted requester.
    - Grant rule: if only one request is valid, grant it. If both are valid, grant the requester != last_grant. If none, stay in IDLE.
    - On the grant edge: latch sel/a/b/cin/bin and id into operand registers, update last_grant, go to EXEC.
  - EXEC:
    - The ALU sees only the operand registers.
    - At the edge, capture Y and the flags into the out_* registers, set out_valid, go to RESP.
  - RESP:
    - out_valid = 1; out_* are held stable while out_ready = 0.
    - On an edge with out_ready = 1: clear out_valid, increment the counter for out_id, go to IDLE.
    - out_y, out_id and the flags keep their last values after out_valid drops.
- Latency and throughput:
  - If the accept (grant) edge is T, out_valid rises at edge T+1.
  - Minimum 3 cycles per operation.
  - No new grant while in EXEC or RESP.
- Requester rule: reqX operands must stay stable while reqX_valid is high and reqX_ready is low.
- Counters wrap modulo 2^CNT_W with no saturation.
- A request deasserted before it is granted is dropped with no side effect.

Test Plan:
1. Assert rst mid-sequence -> all outputs 0 immediately, without waiting for clk. After release, busy = 0 and req0_ready follows req0_valid.
2. req0 ADD A=200, B=100, Cin=1; out_ready = 1 -> req0_ready high one cycle; out_valid one cycle after accept, with out_y = 301, out_cout = 1, out_id = 0. cnt0 = 1 after the handshake.
3. After reset, both valid in the same cycle: req0 SUB A=254, B=255, Bin=0; req1 SQR A=15 -> req0 first with out_y = 255, out_bout = 1. Then req1 with out_y = 225, out_bout = 0, out_id = 1.
4. CMP A=B=77, out_ready held 0 for 5 cycles -> out_eq = 1, out_valid and all out_* stable, req0_ready and req1_ready = 0, busy = 1. One cycle of out_ready = 1 releases it; state returns to IDLE.
5. Both requests held valid for 4 operations -> grant order 0,1,0,1; cnt0 = cnt1 = 2. Then CNT_W=2 with 4 more req0 operations -> cnt0 wraps to 2.
6. Assert rst during EXEC -> out_valid never rises, the counters clear, and the next request is accepted normally.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one ALU_8bit between two requesters, with a registered
// result/handshake stage and per-requester completion counters.

module ALU_8bit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [1:0]              i_sel,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  input  logic                    i_cin,
  input  logic                    i_bin,
  output logic [2*DATA_WIDTH-1:0] o_y,
  output logic                    o_cout,
  output logic                    o_bout,
  output logic                    o_gr,
  output logic                    o_le,
  output logic                    o_eq
);
  localparam int N = DATA_WIDTH;

  logic [N:0]     w_sum;
  logic [N:0]     w_sub_rhs;
  logic [N:0]     w_diff;
  logic [2*N-1:0] w_sqr;

  // One extra bit on every add/sub so carry and borrow fall out of bit N.
  assign w_sum     = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
  assign w_sub_rhs = {1'b0, i_b} + {{N{1'b0}}, i_bin};
  assign w_diff    = {1'b0, i_a} - w_sub_rhs;
  assign w_sqr     = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_a};

  always_comb begin
    o_y    = '0;
    o_cout = 1'b0;
    o_bout = 1'b0;
    o_gr   = 1'b0;
    o_le   = 1'b0;
    o_eq   = 1'b0;
    case (i_sel)
      2'd0: begin
        o_y    = {{(N-1){1'b0}}, w_sum};
        o_cout = w_sum[N];
      end
      2'd1: begin
        o_y    = {{N{1'b0}}, w_diff[N-1:0]};
        o_bout = ({1'b0, i_a} < w_sub_rhs);
      end
      2'd2: begin
        o_gr = (i_a > i_b);
        o_le = (i_a < i_b);
        o_eq = (i_a == i_b);
      end
      default: o_y = w_sqr;
    endcase
  end
endmodule

module alu_rr_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [1:0]              req0_sel,
  input  logic [DATA_WIDTH-1:0]   req0_a,
  input  logic [DATA_WIDTH-1:0]   req0_b,
  input  logic                    req0_cin,
  input  logic                    req0_bin,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [1:0]              req1_sel,
  input  logic [DATA_WIDTH-1:0]   req1_a,
  input  logic [DATA_WIDTH-1:0]   req1_b,
  input  logic                    req1_cin,
  input  logic                    req1_bin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_id,
  output logic [2*DATA_WIDTH-1:0] out_y,
  output logic                    out_cout,
  output logic                    out_bout,
  output logic                    out_gr,
  output logic                    out_le,
  output logic                    out_eq,
  output logic                    busy,
  output logic [CNT_W-1:0]        cnt0,
  output logic [CNT_W-1:0]        cnt1
);
  localparam int N = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic [1:0]       r_op_sel;
  logic [N-1:0]     r_op_a;
  logic [N-1:0]     r_op_b;
  logic             r_op_cin;
  logic             r_op_bin;
  logic             r_op_id;
  logic             r_out_valid;
  logic             r_out_id;
  logic [2*N-1:0]   r_out_y;
  logic             r_out_cout;
  logic             r_out_bout;
  logic             r_out_gr;
  logic             r_out_le;
  logic             r_out_eq;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_idle;
  logic             w_any_req;
  logic             w_grant_id;
  logic [1:0]       w_req_sel;
  logic [N-1:0]     w_req_a;
  logic [N-1:0]     w_req_b;
  logic             w_req_cin;
  logic             w_req_bin;
  logic [2*N-1:0]   w_alu_y;
  logic             w_alu_cout;
  logic             w_alu_bout;
  logic             w_alu_gr;
  logic             w_alu_le;
  logic             w_alu_eq;

  // Contention goes to the requester that did not win last; a lone request always wins.
  assign w_idle     = (r_state == S_IDLE);
  assign w_any_req  = req0_valid | req1_valid;
  assign w_grant_id = (req0_valid & req1_valid) ? ~r_last_grant : ~req0_valid;

  assign req0_ready = ~rst & w_idle & req0_valid & ~w_grant_id;
  assign req1_ready = ~rst & w_idle & req1_valid & w_grant_id;

  assign w_req_sel = w_grant_id ? req1_sel : req0_sel;
  assign w_req_a   = w_grant_id ? req1_a   : req0_a;
  assign w_req_b   = w_grant_id ? req1_b   : req0_b;
  assign w_req_cin = w_grant_id ? req1_cin : req0_cin;
  assign w_req_bin = w_grant_id ? req1_bin : req0_bin;

  ALU_8bit #(
    .DATA_WIDTH (N)
  ) u_alu (
    .i_sel  (r_op_sel),
    .i_a    (r_op_a),
    .i_b    (r_op_b),
    .i_cin  (r_op_cin),
    .i_bin  (r_op_bin),
    .o_y    (w_alu_y),
    .o_cout (w_alu_cout),
    .o_bout (w_alu_bout),
    .o_gr   (w_alu_gr),
    .o_le   (w_alu_le),
    .o_eq   (w_alu_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_op_sel     <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_cin     <= 1'b0;
      r_op_bin     <= 1'b0;
      r_op_id      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_id     <= 1'b0;
      r_out_y      <= '0;
      r_out_cout   <= 1'b0;
      r_out_bout   <= 1'b0;
      r_out_gr     <= 1'b0;
      r_out_le     <= 1'b0;
      r_out_eq     <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_op_sel     <= w_req_sel;
            r_op_a       <= w_req_a;
            r_op_b       <= w_req_b;
            r_op_cin     <= w_req_cin;
            r_op_bin     <= w_req_bin;
            r_op_id      <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_out_y     <= w_alu_y;
          r_out_cout  <= w_alu_cout;
          r_out_bout  <= w_alu_bout;
          r_out_gr    <= w_alu_gr;
          r_out_le    <= w_alu_le;
          r_out_eq    <= w_alu_eq;
          r_out_id    <= r_op_id;
          r_out_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          // Result fields stay put after the handshake; only valid drops.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_id) r_cnt1 <= r_cnt1 + 1'b1;
            else          r_cnt0 <= r_cnt0 + 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;
  assign out_y     = r_out_y;
  assign out_cout  = r_out_cout;
  assign out_bout  = r_out_bout;
  assign out_gr    = r_out_gr;
  assign out_le    = r_out_le;
  assign out_eq    = r_out_eq;
  assign busy      = ~w_idle;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: reset, latency, arbitration, back-pressure,
// counter wrap and reset during execution.

module tb_alu_rr_scheduler;
  localparam int N  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [1:0]    req0_sel = '0, req1_sel = '0;
  logic [N-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          req0_cin = 1'b0, req0_bin = 1'b0, req1_cin = 1'b0, req1_bin = 1'b0;
  logic          out_valid, out_id;
  logic          out_ready = 1'b0;
  logic [2*N-1:0] out_y;
  logic          out_cout, out_bout, out_gr, out_le, out_eq, busy;
  logic [CW-1:0] cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.DATA_WIDTH(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_bin(req0_bin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_bin(req1_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_y(out_y),
    .out_cout(out_cout), .out_bout(out_bout), .out_gr(out_gr), .out_le(out_le),
    .out_eq(out_eq), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [1:0] s, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic ci, input logic bi);
    req0_valid = v; req0_sel = s; req0_a = a; req0_b = b; req0_cin = ci; req0_bin = bi;
  endtask

  task automatic drive1(input logic v, input logic [1:0] s, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic ci, input logic bi);
    req1_valid = v; req1_sel = s; req1_a = a; req1_b = b; req1_cin = ci; req1_bin = bi;
  endtask

  // Bounded wait for a result; an expired bound shows up as a failed check.
  task automatic wait_out(input string tag);
    int k = 0;
    #1;
    while (!out_valid && k < 8) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, "_out_valid"}, 32'(out_valid), 1);
  endtask

  initial begin
    // Reset state, with a request pending that must not be acknowledged
    req0_valid = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    req0_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_busy", 32'(busy), 0);

    // ADD 200+100+1, exact latency
    @(negedge clk);
    drive0(1, 2'd0, 8'd200, 8'd100, 1, 0);
    out_ready = 1'b1;
    #1 chk("t2_ready0", 32'(req0_ready), 1);
    chk("t2_ready1", 32'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1 chk("t2_ready0_exec", 32'(req0_ready), 0);
    chk("t2_busy_exec", 32'(busy), 1);
    chk("t2_valid_exec", 32'(out_valid), 0);
    @(negedge clk);
    #1 chk("t2_valid", 32'(out_valid), 1);
    chk("t2_y", 32'(out_y), 301);
    chk("t2_cout", 32'(out_cout), 1);
    chk("t2_id", 32'(out_id), 0);
    @(negedge clk);
    #1 chk("t2_valid_drop", 32'(out_valid), 0);
    chk("t2_cnt0", 32'(cnt0), 1);
    chk("t2_busy_idle", 32'(busy), 0);
    chk("t2_y_held", 32'(out_y), 301);

    // Async reset while a result is waiting in RESP
    @(negedge clk);
    out_ready = 1'b0;
    drive0(1, 2'd3, 8'd12, 8'd0, 0, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_out("t1");
    chk("t1_y", 32'(out_y), 144);
    #2 rst = 1'b1;
    #1 chk("t1_out_valid", 32'(out_valid), 0);
    chk("t1_out_y", 32'(out_y), 0);
    chk("t1_cnt0", 32'(cnt0), 0);
    chk("t1_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1;
    #1 chk("t1_ready_follow", 32'(req0_ready), 1);
    req0_valid = 1'b0;
    #1 chk("t1_ready_drop", 32'(req0_ready), 0);
    @(negedge clk);
    #1 chk("t1_dropped_busy", 32'(busy), 0);

    // Simultaneous requests: req0 SUB wins, then req1 SQR
    @(negedge clk);
    drive0(1, 2'd1, 8'd254, 8'd255, 0, 0);
    drive1(1, 2'd3, 8'd15, 8'd0, 0, 0);
    out_ready = 1'b1;
    #1 chk("t3_ready0", 32'(req0_ready), 1);
    chk("t3_ready1", 32'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_out("t3a");
    chk("t3a_y", 32'(out_y), 255);
    chk("t3a_bout", 32'(out_bout), 1);
    chk("t3a_id", 32'(out_id), 0);
    @(negedge clk);
    #1 chk("t3_ready1_next", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_out("t3b");
    chk("t3b_y", 32'(out_y), 225);
    chk("t3b_bout", 32'(out_bout), 0);
    chk("t3b_id", 32'(out_id), 1);
    @(negedge clk);
    #1 chk("t3_cnt0", 32'(cnt0), 1);
    chk("t3_cnt1", 32'(cnt1), 1);

    // CMP 77,77 under back-pressure with both requesters waiting
    @(negedge clk);
    out_ready = 1'b0;
    drive0(1, 2'd2, 8'd77, 8'd77, 0, 0);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_out("t4");
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_hold_valid", 32'(out_valid), 1);
      chk("t4_hold_eq", 32'(out_eq), 1);
      chk("t4_hold_y", 32'(out_y), 0);
      chk("t4_hold_ready0", 32'(req0_ready), 0);
      chk("t4_hold_ready1", 32'(req1_ready), 0);
      chk("t4_hold_busy", 32'(busy), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready = 1'b0;
    #1 chk("t4_release_valid", 32'(out_valid), 0);
    chk("t4_release_busy", 32'(busy), 0);
    chk("t4_eq_held", 32'(out_eq), 1);
    chk("t4_cnt0", 32'(cnt0), 2);

    // Round-robin with both held valid: order 0,1,0,1
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive0(1, 2'd0, 8'd1, 8'd2, 0, 0);
    drive1(1, 2'd0, 8'd3, 8'd4, 0, 0);
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      logic exp_id;
      exp_id = (i % 2 == 1);
      while (!(req0_ready | req1_ready) && k < 8) begin
        @(negedge clk); #1;
        k++;
      end
      chk("t5_ready0", 32'(req0_ready), 32'(!exp_id));
      chk("t5_ready1", 32'(req1_ready), 32'(exp_id));
      @(negedge clk); @(negedge clk);
      #1 chk("t5_valid", 32'(out_valid), 1);
      chk("t5_id", 32'(out_id), 32'(exp_id));
      chk("t5_y", 32'(out_y), exp_id ? 7 : 3);
      @(negedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1 chk("t5_cnt0", 32'(cnt0), 2);
    chk("t5_cnt1", 32'(cnt1), 2);

    // Counter wrap: 256 more req0 operations bring cnt0 back to 2
    @(negedge clk);
    req0_valid = 1'b1;
    repeat (762) @(negedge clk);
    #1 chk("t5_wrap_zero", 32'(cnt0), 0);
    repeat (6) @(negedge clk);
    req0_valid = 1'b0;
    #1 chk("t5_wrap_cnt0", 32'(cnt0), 2);
    chk("t5_wrap_cnt1", 32'(cnt1), 2);
    chk("t5_wrap_busy", 32'(busy), 0);

    // Reset during EXEC discards the operation
    @(negedge clk);
    drive1(1, 2'd0, 8'd50, 8'd60, 1, 0);
    #1 chk("t6_ready1", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 1'b0;
    #1 chk("t6_busy_exec", 32'(busy), 1);
    #2 rst = 1'b1;
    #1 chk("t6_out_valid", 32'(out_valid), 0);
    chk("t6_cnt0", 32'(cnt0), 0);
    chk("t6_cnt1", 32'(cnt1), 0);
    chk("t6_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk("t6_no_valid", 32'(out_valid), 0);
    end
    @(negedge clk);
    drive1(1, 2'd1, 8'd10, 8'd3, 0, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    wait_out("t6");
    chk("t6_y", 32'(out_y), 6);
    chk("t6_id", 32'(out_id), 1);
    chk("t6_bout", 32'(out_bout), 0);
    @(negedge clk);
    #1 chk("t6_cnt1_after", 32'(cnt1), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
